// File: rtl/fc_argmax_classifier_pkg.sv
// Shared types and constants for the BNN fully-connected output stage.
// Package name bnn_fc_pkg is used by the classifier, its comparator and the interface.
package bnn_fc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } fc_state_t;

  localparam int FC_SCORE_W    = 7;   // holds 2*pop-54 over -54..+54
  localparam int FC_POP_LEN    = 54;
  localparam int FC_NCLASS_DEF = 10;

endpackage

// File: rtl/fc_argmax_classifier_if.sv
// Score-vector / result bundle between the FC neurons, the classifier and the result side.
// oMARGIN/oLOW_CONF carry data only when FC_ARGMAX_MARGIN_EN is defined.
interface fc_argmax_classifier_if #(
  parameter int OL     = 7,
  parameter int NCLASS = 10,
  parameter int IW     = 4
);
  logic                 iSTART;
  logic [NCLASS*OL-1:0] iSCORES;
  logic                 oBUSY;
  logic                 oVALID;
  logic [IW-1:0]        oCLASS;
  logic [OL-1:0]        oMAX_SCORE;
  logic [OL:0]          oMARGIN;
  logic                 oLOW_CONF;

  modport master (
    output iSTART, iSCORES,
    input  oBUSY, oVALID, oCLASS, oMAX_SCORE, oMARGIN, oLOW_CONF
  );

  modport slave (
    input  iSTART, iSCORES,
    output oBUSY, oVALID, oCLASS, oMAX_SCORE, oMARGIN, oLOW_CONF
  );
endinterface

// File: rtl/fc_argmax_classifier_score_cmp.sv
// Signed compare-and-select of one candidate against the running best (ties keep lower index).
// Runner-up tracking is present only when FC_ARGMAX_MARGIN_EN is defined.
module fc_score_cmp #(
  parameter int OL = 7,
  parameter int IW = 4
) (
  input  logic signed [OL-1:0] cand_score,
  input  logic [IW-1:0]        cand_idx,
  input  logic signed [OL-1:0] best_score,
  input  logic [IW-1:0]        best_idx,
  output logic signed [OL-1:0] best_score_nxt,
  output logic [IW-1:0]        best_idx_nxt
`ifdef FC_ARGMAX_MARGIN_EN
  ,
  input  logic signed [OL-1:0] second_score,
  output logic signed [OL-1:0] second_nxt
`endif
);
  logic take;

  assign take = cand_score > best_score;

  always_comb begin
    best_score_nxt = best_score;
    best_idx_nxt   = best_idx;
    if (take) begin
      best_score_nxt = cand_score;
      best_idx_nxt   = cand_idx;
    end
  end

`ifdef FC_ARGMAX_MARGIN_EN
  // A tie with the best falls through to the runner-up, giving a zero margin.
  always_comb begin
    second_nxt = second_score;
    if (take) begin
      second_nxt = best_score;
    end else if (cand_score > second_score) begin
      second_nxt = cand_score;
    end
  end
`endif
endmodule

// File: rtl/fc_argmax_classifier.sv
// Sequential argmax over NCLASS captured FC scores, one class per clock.
// Optional runner-up margin / low-confidence flag enabled by FC_ARGMAX_MARGIN_EN.
//
// state | meaning
// IDLE  | waiting for iSTART
// SCAN  | comparing buffered score[idx] against running best
// DONE  | oVALID pulse; iSTART here starts the next vector with no bubble
module fc_argmax_classifier
  import bnn_fc_pkg::*;
#(
  parameter int OL     = FC_SCORE_W,
  parameter int NCLASS = FC_NCLASS_DEF,
  parameter int IW     = 4,
  parameter int THR    = 8
) (
  input logic                 iCLK,
  input logic                 iRST_N,
  fc_argmax_classifier_if.slave bus
);
  fc_state_t state_q, state_d;
  logic load, step, finish;

  logic signed [OL-1:0] score_buf [NCLASS];
  logic [IW-1:0]        idx_q;
  logic signed [OL-1:0] best_q, best_nxt;
  logic [IW-1:0]        best_idx_q, best_idx_nxt;
  logic [IW-1:0]        class_q;
  logic signed [OL-1:0] max_q;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.iSTART) begin
          load    = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        step = 1'b1;
        if (idx_q == IW'(NCLASS-1)) begin
          finish  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.iSTART) begin
          load    = 1'b1;
          state_d = ST_SCAN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef FC_ARGMAX_MARGIN_EN
  logic signed [OL-1:0] second_q, second_nxt;
  logic [OL:0]          margin_nxt, margin_q;
  logic                 low_q;

  fc_score_cmp #(.OL(OL), .IW(IW)) u_cmp (
    .cand_score     (score_buf[idx_q]),
    .cand_idx       (idx_q),
    .best_score     (best_q),
    .best_idx       (best_idx_q),
    .best_score_nxt (best_nxt),
    .best_idx_nxt   (best_idx_nxt),
    .second_score   (second_q),
    .second_nxt     (second_nxt)
  );

  // Sign-extended difference is never negative, so it reads as unsigned.
  assign margin_nxt = {best_nxt[OL-1], best_nxt} - {second_nxt[OL-1], second_nxt};

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      second_q <= '0;
      margin_q <= '0;
      low_q    <= 1'b0;
    end else begin
      if (load) second_q <= {1'b1, {(OL-1){1'b0}}};
      else if (step) second_q <= second_nxt;
      if (finish) begin
        margin_q <= margin_nxt;
        low_q    <= margin_nxt < (OL+1)'(THR);
      end
    end
  end

  assign bus.oMARGIN   = margin_q;
  assign bus.oLOW_CONF = low_q;
`else
  fc_score_cmp #(.OL(OL), .IW(IW)) u_cmp (
    .cand_score     (score_buf[idx_q]),
    .cand_idx       (idx_q),
    .best_score     (best_q),
    .best_idx       (best_idx_q),
    .best_score_nxt (best_nxt),
    .best_idx_nxt   (best_idx_nxt)
  );

  assign bus.oMARGIN   = '0;
  assign bus.oLOW_CONF = 1'b0;
`endif

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int c = 0; c < NCLASS; c++) score_buf[c] <= '0;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      class_q    <= '0;
      max_q      <= '0;
    end else begin
      if (load) begin
        for (int c = 0; c < NCLASS; c++) score_buf[c] <= bus.iSCORES[c*OL +: OL];
        best_q     <= bus.iSCORES[OL-1:0];
        best_idx_q <= '0;
        idx_q      <= IW'(1);
      end else if (step) begin
        best_q     <= best_nxt;
        best_idx_q <= best_idx_nxt;
        idx_q      <= idx_q + IW'(1);
      end
      if (finish) begin
        class_q <= best_idx_nxt;
        max_q   <= best_nxt;
      end
    end
  end

  assign bus.oBUSY      = (state_q == ST_SCAN);
  assign bus.oVALID     = (state_q == ST_DONE);
  assign bus.oCLASS     = class_q;
  assign bus.oMAX_SCORE = max_q;
endmodule

// File: tb/tb_fc_argmax_classifier.sv
// Self-checking bench for fc_argmax_classifier: vector table, random vectors and
// hand-written busy / back-to-back / mid-scan reset sequences, checked by a scoreboard.
module tb_fc_argmax_classifier;
  localparam int OL = 7;
  localparam int NC = 10;
  localparam int IW = 4;
  localparam int THR = 8;
  localparam int SW = NC*OL;

  typedef struct {
    logic [SW-1:0] sc;
    int cls;
    int score;
    int margin;
  } vec_t;

  typedef struct {
    int cls;
    int score;
    int margin;
    int low;
    int k;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   n_valid = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];
  exp_t e;
  vec_t tbl[7];

  fc_argmax_classifier_if #(.OL(OL), .NCLASS(NC), .IW(IW)) bus ();

  fc_argmax_classifier #(.OL(OL), .NCLASS(NC), .IW(IW), .THR(THR)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [SW-1:0] pk10(input int a0, a1, a2, a3, a4, a5, a6, a7, a8, a9);
    int a[10];
    logic [SW-1:0] r;
    a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8, a9};
    r = '0;
    for (int c = 0; c < NC; c++) r[c*OL +: OL] = OL'(a[c]);
    return r;
  endfunction

  function automatic int exp_margin(input int m);
`ifdef FC_ARGMAX_MARGIN_EN
    return m;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_low(input int m);
`ifdef FC_ARGMAX_MARGIN_EN
    return (m < THR) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic int score_at(input logic [SW-1:0] sc, input int c);
    logic signed [OL-1:0] s;
    s = sc[c*OL +: OL];
    return int'(s);
  endfunction

  // Reference: first index of the maximum; runner-up is the max over all other indices.
  function automatic vec_t model(input logic [SW-1:0] sc);
    vec_t v;
    int sec;
    v.sc = sc;
    v.cls = 0;
    v.score = score_at(sc, 0);
    for (int c = 1; c < NC; c++)
      if (score_at(sc, c) > v.score) begin
        v.score = score_at(sc, c);
        v.cls = c;
      end
    sec = -1000;
    for (int c = 0; c < NC; c++)
      if (c != v.cls && score_at(sc, c) > sec) sec = score_at(sc, c);
    v.margin = v.score - sec;
    return v;
  endfunction

  // Caller is at a negedge; returns at the negedge after the accepting edge.
  task automatic start_vec(input vec_t v, input bit push);
    exp_t x;
    bus.iSTART = 1'b1;
    bus.iSCORES = v.sc;
    if (push) begin
      x.cls = v.cls;
      x.score = v.score;
      x.margin = exp_margin(v.margin);
      x.low = exp_low(v.margin);
      x.k = cyc + 1;
      sb.push_back(x);
    end
    @(posedge clk);
    @(negedge clk);
    bus.iSTART = 1'b0;
    bus.iSCORES = ~v.sc;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding after %0d cycles", sb.size(), max_cyc);
      sb.delete();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.oBUSY), 0);
    chk({tag, "_valid"}, int'(bus.oVALID), 0);
    chk({tag, "_class"}, int'(bus.oCLASS), 0);
    chk({tag, "_score"}, int'(bus.oMAX_SCORE), 0);
    chk({tag, "_margin"}, int'(bus.oMARGIN), 0);
    chk({tag, "_lowconf"}, int'(bus.oLOW_CONF), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.oVALID) begin
      n_valid++;
      chk("valid_one_cycle", int'(prev_valid), 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: oVALID=1 with no result expected (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("class", int'(bus.oCLASS), e.cls);
        chk("max_score", score_at({{(SW-OL){1'b0}}, bus.oMAX_SCORE}, 0), e.score);
        chk("margin", int'(bus.oMARGIN), e.margin);
        chk("low_conf", int'(bus.oLOW_CONF), e.low);
        chk("latency", cyc - e.k, NC - 1);
      end
    end
    prev_valid = bus.oVALID;
  end

  initial begin
    vec_t v;
    int   v0;
    logic [SW-1:0] r;

    rst_n = 1'b0;
    bus.iSTART = 1'b0;
    bus.iSCORES = '0;

    tbl[0] = '{pk10(-54, -2, 10, 40, -6, 0, 3, 8, -20, 12), 3, 40, 28};
    tbl[1] = '{pk10(-54, -54, -54, -54, -54, -54, -54, -54, -54, -54), 0, -54, 0};
    tbl[2] = '{pk10(0, 0, 0, 0, 20, 0, 0, 20, 0, 0), 4, 20, 0};
    tbl[3] = '{pk10(36, 0, 0, 0, 0, 0, 0, 0, 0, 40), 9, 40, 4};
    tbl[4] = '{pk10(-54, -54, -54, -54, -54, 54, -54, -54, -54, -54), 5, 54, 108};
    tbl[5] = '{pk10(50, 49, -1, 0, 0, 0, 0, 0, 0, 0), 0, 50, 1};
    tbl[6] = '{pk10(0, 8, -10, -10, -10, -10, -10, -10, -10, -10), 1, 8, 8};

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      start_vec(tbl[i], 1'b1);
      wait_drain(30);
      @(negedge clk);
      chk("hold_class", int'(bus.oCLASS), tbl[i].cls);
    end

    for (int i = 0; i < 6; i++) begin
      r = '0;
      for (int c = 0; c < NC; c++) r[c*OL +: OL] = OL'(int'($urandom_range(0, 108)) - 54);
      v = model(r);
      start_vec(v, 1'b1);
      wait_drain(30);
    end

    // iSTART during SCAN must be ignored
    @(negedge clk);
    v0 = n_valid;
    start_vec(tbl[0], 1'b1);
    repeat (2) @(negedge clk);
    chk("busy_in_scan", int'(bus.oBUSY), 1);
    bus.iSTART = 1'b1;
    bus.iSCORES = tbl[4].sc;
    @(negedge clk);
    bus.iSTART = 1'b0;
    wait_drain(30);
    repeat (12) @(negedge clk);
    chk("busy_ignore_pulses", n_valid - v0, 1);
    chk("busy_after_done", int'(bus.oBUSY), 0);

    // back-to-back: second iSTART presented while in DONE
    v0 = n_valid;
    start_vec(tbl[3], 1'b1);
    for (int n = 0; n < 20 && !bus.oVALID; n++) @(negedge clk);
    if (bus.oVALID) start_vec(tbl[2], 1'b1);
    else chk("b2b_done_seen", 0, 1);
    wait_drain(30);
    repeat (3) @(negedge clk);
    chk("b2b_pulses", n_valid - v0, 2);

    // reset mid-scan aborts with no result
    v0 = n_valid;
    start_vec(tbl[4], 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("midrst_no_valid", n_valid - v0, 0);

    start_vec(tbl[0], 1'b1);
    wait_drain(30);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
